// File: rtl/binary_counter.sv
// Free-running LED heartbeat counter: a prescaler divides clock by TICK_DIVIDE
// and the LED register advances by one (mod 2^LED_WIDTH) on each prescaler reload.
module binary_counter #(
  parameter int LED_WIDTH   = 8,
  parameter int TICK_DIVIDE = 1000
) (
  input  logic                 clock,
  input  logic                 reset_n,
  output logic [LED_WIDTH-1:0] led
);

  localparam int PW = (TICK_DIVIDE > 1) ? $clog2(TICK_DIVIDE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIVIDE - 1);

  logic [PW-1:0]        presc_q, presc_d;
  logic [LED_WIDTH-1:0] count_q, count_d;
  logic                 tick;

  // With TICK_DIVIDE=1 PRESC_LAST is 0, so the prescaler sits at 0 and tick is constant high.
  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    presc_d = tick ? '0 : presc_q + PW'(1);
    count_d = tick ? count_q + LED_WIDTH'(1) : count_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      count_q <= '0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
    end
  end

  assign led = count_q;

endmodule

// File: tb/tb_binary_counter.sv
// Self-checking bench: four counter configurations share one clock; each is
// compared with led = floor(edges_since_release / TICK_DIVIDE) mod 2^LED_WIDTH.
module tb_binary_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_td4, rst_td1, rst_sw, rst_def;
  logic [7:0] led_td4, led_td1, led_def;
  logic [3:0] led_sw;

  binary_counter #(.LED_WIDTH(8), .TICK_DIVIDE(4)) u_td4 (.clock(clk), .reset_n(rst_td4), .led(led_td4));
  binary_counter #(.LED_WIDTH(8), .TICK_DIVIDE(1)) u_td1 (.clock(clk), .reset_n(rst_td1), .led(led_td1));
  binary_counter #(.LED_WIDTH(4), .TICK_DIVIDE(3)) u_sw  (.clock(clk), .reset_n(rst_sw),  .led(led_sw));
  binary_counter u_def (.clock(clk), .reset_n(rst_def), .led(led_def));

  // Reference: number of rising edges seen since the most recent reset release.
  longint n_td4, n_td1, n_sw, n_def;
  always @(posedge clk or negedge rst_td4) if (!rst_td4) n_td4 <= 0; else n_td4 <= n_td4 + 1;
  always @(posedge clk or negedge rst_td1) if (!rst_td1) n_td1 <= 0; else n_td1 <= n_td1 + 1;
  always @(posedge clk or negedge rst_sw)  if (!rst_sw)  n_sw  <= 0; else n_sw  <= n_sw  + 1;
  always @(posedge clk or negedge rst_def) if (!rst_def) n_def <= 0; else n_def <= n_def + 1;

  int errors = 0;
  int checks = 0;

  function automatic logic [7:0] model(input longint n, input int td, input int w);
    longint ticks;
    ticks = n / td;
    return 8'(ticks % (longint'(1) << w));
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_td4"}, led_td4, model(n_td4, 4, 8));
    check({tag, "_td1"}, led_td1, model(n_td1, 1, 8));
    check({tag, "_sw"},  {4'b0, led_sw}, model(n_sw, 3, 4));
    check({tag, "_def"}, led_def, model(n_def, 1000, 8));
  endtask

  initial begin
    int guard;
    rst_td4 = 1'b0; rst_td1 = 1'b0; rst_sw = 1'b0; rst_def = 1'b0;

    // Reset held for 5 clocks: every LED bank reads zero throughout.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_hold_td4", led_td4, 8'h00);
      check("rst_hold_td1", led_td1, 8'h00);
      check("rst_hold_sw",  {4'b0, led_sw}, 8'h00);
      check("rst_hold_def", led_def, 8'h00);
    end

    rst_td4 = 1'b1; rst_td1 = 1'b1; rst_sw = 1'b1; rst_def = 1'b1;

    // Edge-by-edge trace covering cadence, sweep wrap and 8-bit wrap.
    for (int e = 1; e <= 260; e++) begin
      @(negedge clk);
      check_all("trace");
      if (e == 3)   check("td4_before_first", led_td4, 8'h00);
      if (e == 4)   check("td4_edge4",  led_td4, 8'h01);
      if (e == 8)   check("td4_edge8",  led_td4, 8'h02);
      if (e == 40)  check("td4_edge40", led_td4, 8'h0A);
      if (e == 48)  check("sw_edge48",  {4'b0, led_sw}, 8'h00);
      if (e == 51)  check("sw_edge51",  {4'b0, led_sw}, 8'h01);
      if (e == 255) check("td1_edge255", led_td1, 8'hFF);
      if (e == 256) check("td1_edge256", led_td1, 8'h00);
      if (e == 257) check("td1_edge257", led_td1, 8'h01);
    end

    // Advance until the TICK_DIVIDE=1 counter shows 0x37, then reset it between edges.
    guard = 0;
    while (led_td1 !== 8'h37 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("td1_reach_37", led_td1, 8'h37);
    #2 rst_td1 = 1'b0;
    #1 check("td1_async_clear", led_td1, 8'h00);
    @(negedge clk);
    check("td1_held_in_reset", led_td1, 8'h00);
    rst_td1 = 1'b1;
    @(negedge clk);
    check("td1_first_after_release", led_td1, 8'h01);
    check_all("post_async");

    // Randomised mid-run reset of the TICK_DIVIDE=4 counter.
    repeat ($urandom_range(1, 9)) @(negedge clk);
    #2 rst_td4 = 1'b0;
    #1 check("td4_async_clear", led_td4, 8'h00);
    @(negedge clk);
    rst_td4 = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      check("td4_restart", led_td4, (e == 4) ? 8'h01 : 8'h00);
    end

    // Random run lengths, checking every configuration against the model.
    for (int r = 0; r < 25; r++) begin
      repeat ($urandom_range(1, 700)) @(negedge clk);
      check_all("random");
    end

    // Default configuration: run to 50000 edges since release -> 50 ticks.
    guard = 0;
    while (n_def < 50000 && guard < 60000) begin
      @(negedge clk);
      guard++;
    end
    check("def_edge_count_reached", (n_def == 50000) ? 8'h01 : 8'h00, 8'h01);
    check("def_final", led_def, 8'h32);
    check_all("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
